// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the memory responder and its clients.
//   - mem_state_e : responder FSM encoding (IDLE, WAIT, RESP)
//   - MEM_COUNT_RAM_WORD / MEM_SIZE_WORD : default array geometry
//   - MEM_BE_W    : byte-enable width for a 32-bit word
//   - MEM_CNT_W   : latency counter width (LATENCY range 1..15)
//   - mem_word_in_range() : word-index bound check on a byte address
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } mem_state_e;

    localparam int MEM_COUNT_RAM_WORD = 1024;
    localparam int MEM_SIZE_WORD      = 32;
    localparam int MEM_BE_W           = MEM_SIZE_WORD / 8;
    localparam int MEM_CNT_W          = 4;

    // True when the word index addr[31:2] addresses an existing word.
    function automatic logic mem_word_in_range(input logic [31:0] addr,
                                               input int unsigned words);
        logic [31:0] idx;
        idx = {2'b00, addr[31:2]};
        return (idx < words);
    endfunction

endpackage

// File: rtl/mem_array.sv
// mem_array: synchronous single-port word array with per-byte write enable.
// Ports:
//   clk_i    - clock, rising edge
//   en_i     - access strobe for this cycle
//   we_i     - 1 = write, 0 = read
//   be_i     - byte enables for writes
//   addr_i   - word index
//   wdata_i  - write data
//   rdata_o  - registered read data; holds until the next read access
// Contents are never cleared.
module mem_array
    import mem_pkg::*;
#(
    parameter int COUNT_RAM_WORD = MEM_COUNT_RAM_WORD,
    parameter int SIZE_WORD      = MEM_SIZE_WORD,
    parameter int AW             = (COUNT_RAM_WORD > 1) ? $clog2(COUNT_RAM_WORD) : 1
) (
    input  logic                   clk_i,
    input  logic                   en_i,
    input  logic                   we_i,
    input  logic [SIZE_WORD/8-1:0] be_i,
    input  logic [AW-1:0]          addr_i,
    input  logic [SIZE_WORD-1:0]   wdata_i,
    output logic [SIZE_WORD-1:0]   rdata_o
);

    logic [SIZE_WORD-1:0] mem_q [COUNT_RAM_WORD];
    logic [SIZE_WORD-1:0] rdata_q;

    // Byte-masked write port.
    always_ff @(posedge clk_i) begin
        if (en_i && we_i) begin
            for (int b = 0; b < SIZE_WORD / 8; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Registered read port; output is held between reads.
    always_ff @(posedge clk_i) begin
        if (en_i && !we_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding valid/ready memory responder.
// Ports:
//   clk, rst (sync, active-high)
//   req_valid/req_ready, req_we, req_addr (byte address), req_wdata, req_be
//   resp_valid/resp_ready, resp_rdata, resp_err
// A request is accepted in IDLE, waits LATENCY-1 further cycles in WAIT,
// performs the array access on the edge that leaves WAIT and presents the
// result in RESP until resp_ready.
// Optional macro MEM_MISALIGN_ERR_EN: addr[1:0] != 0 is reported as an error.
module mem_responder
    import mem_pkg::*;
#(
    parameter int COUNT_RAM_WORD = MEM_COUNT_RAM_WORD,
    parameter int SIZE_WORD      = MEM_SIZE_WORD,
    parameter int LATENCY        = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [31:0]            req_addr,
    input  logic [SIZE_WORD-1:0]   req_wdata,
    input  logic [SIZE_WORD/8-1:0] req_be,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [SIZE_WORD-1:0]   resp_rdata,
    output logic                   resp_err
);

    localparam int AW = (COUNT_RAM_WORD > 1) ? $clog2(COUNT_RAM_WORD) : 1;

    mem_state_e             state_q, state_d;
    logic [MEM_CNT_W-1:0]   cnt_q, cnt_d;
    logic                   we_q, we_d;
    logic [31:0]            addr_q, addr_d;
    logic [SIZE_WORD-1:0]   wdata_q, wdata_d;
    logic [SIZE_WORD/8-1:0] be_q, be_d;
    logic                   err_q, err_d;
    logic                   rd_ok_q, rd_ok_d;

    logic                   acc_err_s;
    logic                   mem_en_s;
    logic [SIZE_WORD-1:0]   mem_rdata_s;

    // Error classification of the latched request.
`ifdef MEM_MISALIGN_ERR_EN
    assign acc_err_s = !mem_word_in_range(addr_q, COUNT_RAM_WORD)
                     || (addr_q[1:0] != 2'b00);
`else
    assign acc_err_s = !mem_word_in_range(addr_q, COUNT_RAM_WORD);
`endif

    // Next-state, counter and response-flag logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        err_d    = err_q;
        rd_ok_d  = rd_ok_q;
        mem_en_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    cnt_d   = MEM_CNT_W'(LATENCY - 1);
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == {MEM_CNT_W{1'b0}}) begin
                    // Access happens on this edge; erroring requests touch nothing.
                    mem_en_s = !acc_err_s;
                    err_d    = acc_err_s;
                    rd_ok_d  = !we_q && !acc_err_s;
                    state_d  = ST_RESP;
                end else begin
                    cnt_d = cnt_q - {{(MEM_CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    err_d   = 1'b0;
                    rd_ok_d = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                err_d   = 1'b0;
                rd_ok_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and request/response registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= {MEM_CNT_W{1'b0}};
            we_q    <= 1'b0;
            addr_q  <= 32'h0000_0000;
            wdata_q <= {SIZE_WORD{1'b0}};
            be_q    <= {(SIZE_WORD/8){1'b0}};
            err_q   <= 1'b0;
            rd_ok_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            err_q   <= err_d;
            rd_ok_q <= rd_ok_d;
        end
    end

    // Reset gates the strobe so an abandoned write never commits.
    mem_array #(
        .COUNT_RAM_WORD (COUNT_RAM_WORD),
        .SIZE_WORD      (SIZE_WORD),
        .AW             (AW)
    ) u_mem_array (
        .clk_i   (clk),
        .en_i    (mem_en_s && !rst),
        .we_i    (we_q),
        .be_i    (be_q),
        .addr_i  (addr_q[AW+1:2]),
        .wdata_i (wdata_q),
        .rdata_o (mem_rdata_s)
    );

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_err   = err_q;
    // Array output is only exposed for successful reads; otherwise zero.
    assign resp_rdata = rd_ok_q ? mem_rdata_s : {SIZE_WORD{1'b0}};

endmodule

// File: tb/tb_mem_responder.sv
// Directed, table-driven bench for mem_responder (LATENCY = 3).
module tb_mem_responder;

    localparam int LAT = 3;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int n_checks;
    int n_err;

    mem_responder #(
        .COUNT_RAM_WORD (1024),
        .SIZE_WORD      (32),
        .LATENCY        (LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_be     (req_be),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One full transaction; checks latency, ready, response and stall stability.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input logic [31:0] exp_rdata,
                       input logic exp_err, input int nstall);
        int lat;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        chk("ready_idle", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 20) begin
            chk("ready_busy", {31'd0, req_ready}, 32'd0);
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", lat, LAT);
        chk("rdata", resp_rdata, exp_rdata);
        chk("err", {31'd0, resp_err}, {31'd0, exp_err});
        for (int i = 0; i < nstall; i++) begin
            @(posedge clk);
            #1;
            chk("stall_valid", {31'd0, resp_valid}, 32'd1);
            chk("stall_rdata", resp_rdata, exp_rdata);
            chk("stall_err", {31'd0, resp_err}, {31'd0, exp_err});
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        chk("valid_after_consume", {31'd0, resp_valid}, 32'd0);
        chk("ready_after_consume", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        n_checks   = 0;
        n_err      = 0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        req_be     = 4'h0;
        resp_ready = 1'b0;

        //          we    addr           wdata          be       exp_rdata      err
        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF,    32'h0,         1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0,    32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h0000_0010, 32'h1122_3344, 4'b0101, 32'h0,         1'b0};
        vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0,         4'hF,    32'hDE22_BE44, 1'b0};
        vecs[4]  = '{1'b0, 32'h0000_1000, 32'h0,         4'hF,    32'h0,         1'b1};
        vecs[5]  = '{1'b1, 32'h0000_1000, 32'hFFFF_FFFF, 4'hF,    32'h0,         1'b1};
        vecs[6]  = '{1'b1, 32'h0000_0000, 32'hA5A5_A5A5, 4'hF,    32'h0,         1'b0};
        vecs[7]  = '{1'b0, 32'h0000_0000, 32'h0,         4'h0,    32'hA5A5_A5A5, 1'b0};
        vecs[8]  = '{1'b1, 32'h0000_0020, 32'hCAFE_F00D, 4'hF,    32'h0,         1'b0};
        vecs[9]  = '{1'b1, 32'h0000_0020, 32'h1234_5678, 4'h0,    32'h0,         1'b0};
        vecs[10] = '{1'b1, 32'h0000_0FFC, 32'h0BAD_F00D, 4'hF,    32'h0,         1'b0};
        vecs[11] = '{1'b0, 32'h0000_0FFC, 32'h0,         4'hF,    32'h0BAD_F00D, 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_err", {31'd0, resp_err}, 32'd0);

        for (int i = 0; i < 12; i++) begin
            txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be,
                vecs[i].exp_rdata, vecs[i].exp_err, 0);
        end

        // Out-of-range writes left word 0 and word 0x10 intact; be=0 left 0x20 intact.
        txn(1'b0, 32'h0000_0010, 32'h0, 4'hF, 32'hDE22_BE44, 1'b0, 0);
        txn(1'b0, 32'h0000_0000, 32'h0, 4'hF, 32'hA5A5_A5A5, 1'b0, 0);
        txn(1'b0, 32'h0000_0020, 32'h0, 4'hF, 32'hCAFE_F00D, 1'b0, 0);

        // Response held for 5 cycles with resp_ready low.
        txn(1'b0, 32'h0000_0010, 32'h0, 4'hF, 32'hDE22_BE44, 1'b0, 5);

        // Reset on the edge that would commit a write to 0x20.
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h0000_0020;
        req_wdata = 32'h5555_5555;
        req_be    = 4'hF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (LAT - 1) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rstwait_valid", {31'd0, resp_valid}, 32'd0);
        chk("rstwait_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("rstwait_idle_valid", {31'd0, resp_valid}, 32'd0);
        txn(1'b0, 32'h0000_0020, 32'h0, 4'hF, 32'hCAFE_F00D, 1'b0, 0);

        // Misaligned read of 0x12.
`ifdef MEM_MISALIGN_ERR_EN
        txn(1'b0, 32'h0000_0012, 32'h0, 4'hF, 32'h0, 1'b1, 0);
`else
        txn(1'b0, 32'h0000_0012, 32'h0, 4'hF, 32'hDE22_BE44, 1'b0, 0);
`endif

        // req_valid held high through a transaction: no accept on the consume edge.
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h0000_0000;
        req_be    = 4'hF;
        @(posedge clk);
        #1;
        req_addr  = 32'h0000_0010;
        repeat (LAT) @(posedge clk);
        #1;
        chk("b2b_valid", {31'd0, resp_valid}, 32'd1);
        chk("b2b_rdata", resp_rdata, 32'hA5A5_A5A5);
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        chk("b2b_no_accept", {31'd0, req_ready}, 32'd1);
        chk("b2b_valid_low", {31'd0, resp_valid}, 32'd0);
        @(posedge clk);
        #1;
        chk("b2b_accept_next", {31'd0, req_ready}, 32'd0);
        req_valid = 1'b0;
        repeat (LAT) @(posedge clk);
        #1;
        chk("b2b2_valid", {31'd0, resp_valid}, 32'd1);
        chk("b2b2_rdata", resp_rdata, 32'hDE22_BE44);
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        chk("b2b2_done", {31'd0, resp_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
